// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_detector
//  Description : Serial bit-pattern detector with a run-time programmable
//                PAT_W-bit pattern, overlapping / non-overlapping matching,
//                a Mealy match flag and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
    parameter int               PAT_W       = 3,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(3'b011),
    parameter bit               RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,        // synchronous, active low
    input  logic             xin,
    input  logic             xin_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    // fill counts 0..PAT_W-1, so $clog2(PAT_W) bits are always enough
    localparam int               c_fill_w   = $clog2(PAT_W);
    localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [PAT_W-1:0]    r_pat;
    logic                r_ovl;
    logic [PAT_W-2:0]    r_hist;      // newest accepted bit in bit 0
    logic [c_fill_w-1:0] r_fill;
    logic [CNT_W-1:0]    r_cnt;

    logic [PAT_W-1:0]    w_window;    // history plus the bit on the wire now
    logic                w_full;
    logic                w_accept;
    logic                w_match;

    // The candidate window is the held history followed by the current bit;
    // building it this way also covers PAT_W=2 where the history is one bit.
    assign w_window = {r_hist, xin};
    assign w_full   = (r_fill == c_fill_max);
    assign w_accept = xin_valid & ~cfg_load;
    assign w_match  = reset & w_accept & w_full & (w_window == r_pat);

    assign y         = w_match;
    assign match_cnt = r_cnt;
    assign busy      = (r_fill != '0);

    // Pattern and overlap mode: reset value or a fresh load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pat <= RST_PATTERN;
            r_ovl <= RST_OVERLAP;
        end else if (cfg_load) begin
            r_pat <= cfg_pattern;
            r_ovl <= cfg_overlap;
        end
    end

    // Bit history and fill level; a load or a non-overlapping match restarts
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_fill <= '0;
        end else if (xin_valid) begin
            if (w_match && !r_ovl) begin
                r_fill <= '0;
            end else begin
                r_hist <= w_window[PAT_W-2:0];
                if (!w_full) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // Saturating match counter; a clear coinciding with a match keeps that match
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= w_match ? c_cnt_one : '0;
        end else if (w_match && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_pattern_detector
//  Description : Directed self-checking bench for seq_pattern_detector.
//                Instance A uses the default 3-bit configuration, instance B
//                a 4-bit pattern with a 2-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A: PAT_W=3, CNT_W=8, reset pattern 011, overlapping
    logic       a_reset, a_xin, a_valid, a_load, a_ovl, a_clr;
    logic [2:0] a_pat;
    logic       a_y, a_busy;
    logic [7:0] a_cnt;

    // Instance B: PAT_W=4, CNT_W=2, reset pattern 0101, overlapping
    logic       b_reset, b_xin, b_valid, b_load, b_ovl, b_clr;
    logic [3:0] b_pat;
    logic       b_y, b_busy;
    logic [1:0] b_cnt;

    seq_pattern_detector u_dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .xin         (a_xin),
        .xin_valid   (a_valid),
        .cfg_load    (a_load),
        .cfg_pattern (a_pat),
        .cfg_overlap (a_ovl),
        .cnt_clr     (a_clr),
        .y           (a_y),
        .match_cnt   (a_cnt),
        .busy        (a_busy)
    );

    seq_pattern_detector #(
        .PAT_W       (4),
        .CNT_W       (2),
        .RST_PATTERN (4'b0101),
        .RST_OVERLAP (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .xin         (b_xin),
        .xin_valid   (b_valid),
        .cfg_load    (b_load),
        .cfg_pattern (b_pat),
        .cfg_overlap (b_ovl),
        .cnt_clr     (b_clr),
        .y           (b_y),
        .match_cnt   (b_cnt),
        .busy        (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on A, check y mid-cycle, then advance past the edge
    task automatic a_step(input logic rst_n, input logic x, input logic v, input logic ld,
                          input logic [2:0] p, input logic o, input logic clr,
                          input logic exp_y, input string tag);
        a_reset = rst_n; a_xin = x; a_valid = v; a_load = ld;
        a_pat = p; a_ovl = o; a_clr = clr;
        #2;
        check(tag, 32'(a_y), 32'(exp_y));
        @(posedge clk);
        #1;
    endtask

    task automatic a_bit(input logic x, input logic exp_y, input string tag);
        a_step(1'b1, x, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, exp_y, tag);
    endtask

    task automatic b_step(input logic rst_n, input logic x, input logic v, input logic ld,
                          input logic [3:0] p, input logic o, input logic clr,
                          input logic exp_y, input string tag);
        b_reset = rst_n; b_xin = x; b_valid = v; b_load = ld;
        b_pat = p; b_ovl = o; b_clr = clr;
        #2;
        check(tag, 32'(b_y), 32'(exp_y));
        @(posedge clk);
        #1;
    endtask

    task automatic b_bit(input logic x, input logic exp_y, input string tag);
        b_step(1'b1, x, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, exp_y, tag);
    endtask

    initial begin
        logic [7:0] s8;
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        a_reset = 1'b0; a_xin = 1'b0; a_valid = 1'b0; a_load = 1'b0;
        a_pat = 3'b000; a_ovl = 1'b0; a_clr = 1'b0;
        b_reset = 1'b0; b_xin = 1'b0; b_valid = 1'b0; b_load = 1'b0;
        b_pat = 4'b0000; b_ovl = 1'b0; b_clr = 1'b0;

        // ---------------- Instance A ----------------
        a_step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "a_y_in_reset");
        a_step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "a_y_in_reset2");
        check("a_rst_cnt", 32'(a_cnt), 32'd0);
        check("a_rst_busy", 32'(a_busy), 32'd0);

        // Default 011 overlapping, stream 0,1,1,0,1,1
        a_bit(1'b0, 1'b0, "a_s1");
        check("a_busy_after_first", 32'(a_busy), 32'd1);
        a_bit(1'b1, 1'b0, "a_s2");
        a_bit(1'b1, 1'b1, "a_s3");
        a_bit(1'b0, 1'b0, "a_s4");
        a_bit(1'b1, 1'b0, "a_s5");
        a_bit(1'b1, 1'b1, "a_s6");
        check("a_cnt_stream", 32'(a_cnt), 32'd2);

        // 0,1 then a 3-cycle gap (xin held high, not valid), then 1
        a_bit(1'b0, 1'b0, "a_g1");
        a_bit(1'b1, 1'b0, "a_g2");
        for (int i = 0; i < 3; i++) begin
            a_step(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "a_gap_y");
            check("a_gap_busy", 32'(a_busy), 32'd1);
        end
        a_bit(1'b1, 1'b1, "a_g_end");
        check("a_cnt_gap", 32'(a_cnt), 32'd3);

        // Load 110 on the cycle that would have completed 011
        a_bit(1'b0, 1'b0, "a_l1");
        a_bit(1'b1, 1'b0, "a_l2");
        a_step(1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, "a_load_y");
        check("a_load_cnt", 32'(a_cnt), 32'd3);
        check("a_load_busy", 32'(a_busy), 32'd0);
        a_bit(1'b1, 1'b0, "a_n1");
        a_bit(1'b1, 1'b0, "a_n2");
        a_bit(1'b0, 1'b1, "a_n3");
        check("a_cnt_newpat", 32'(a_cnt), 32'd4);

        // 0,1 then reset with a 1 presented, then 1: no match; pattern back to 011
        a_bit(1'b0, 1'b0, "a_r1");
        a_bit(1'b1, 1'b0, "a_r2");
        a_step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "a_r_rstcyc");
        check("a_r_cnt", 32'(a_cnt), 32'd0);
        check("a_r_busy", 32'(a_busy), 32'd0);
        a_bit(1'b1, 1'b0, "a_r_next1");
        a_bit(1'b0, 1'b0, "a_r_b2");
        a_bit(1'b1, 1'b0, "a_r_b3");
        a_bit(1'b1, 1'b1, "a_r_b4_011");
        check("a_r_cnt_after", 32'(a_cnt), 32'd1);

        // ---------------- Instance B ----------------
        b_step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "b_reset");
        check("b_rst_cnt", 32'(b_cnt), 32'd0);

        // 0101 overlapping: matches on bits 4, 6, 8
        b_step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, "b_load_ovl");
        s8 = 8'b0101_0101;
        for (int i = 0; i < 8; i++)
            b_bit(s8[7-i], (i == 3 || i == 5 || i == 7), "b_ovl_y");
        check("b_ovl_cnt", 32'(b_cnt), 32'd3);

        // 0101 non-overlapping, with a clear in the load cycle: bits 4 and 8
        b_step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, "b_load_novl");
        check("b_clr_with_load", 32'(b_cnt), 32'd0);
        for (int i = 0; i < 8; i++)
            b_bit(s8[7-i], (i == 3 || i == 7), "b_novl_y");
        check("b_novl_cnt", 32'(b_cnt), 32'd2);

        // Saturation of the 2-bit counter over five matches
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "b_clr0");
        check("b_clr0_cnt", 32'(b_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            b_bit(1'b0, 1'b0, "b_sat_y");
            b_bit(1'b1, 1'b0, "b_sat_y");
            b_bit(1'b0, 1'b0, "b_sat_y");
            b_bit(1'b1, 1'b1, "b_sat_ymatch");
            check("b_sat_cnt", 32'(b_cnt), 32'(sat_exp[k]));
        end

        // Clear together with a match gives 1; clear alone gives 0
        b_bit(1'b0, 1'b0, "b_cm1");
        b_bit(1'b1, 1'b0, "b_cm2");
        b_bit(1'b0, 1'b0, "b_cm3");
        b_step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, "b_clr_match_y");
        check("b_clr_match_cnt", 32'(b_cnt), 32'd1);
        b_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "b_clr_alone");
        check("b_clr_alone_cnt", 32'(b_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
